// File: rtl/icon_read_requester.sv
// Purpose: queues operand read requests and fetches them one at a time from a producer EU tx port.
// Latency: push into an empty FIFO while idle -> tx request 2 cycles later; success -> response next cycle.
// Backpressure: req_ready_o drops when the FIFO is full; a held response waits for resp_ready_i.
// Optional feature: define ICON_REQ_TIMEOUT_EN to abort a read after MAX_RETRY unsuccessful REQ cycles.
module icon_read_requester #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int LOG2_DEPTH = 2,
    parameter int MAX_RETRY  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    output logic [ADDR_W-1:0] icon_tx_addr_o,
    output logic              icon_tx_req_valid_o,
    input  logic [DATA_W-1:0] icon_tx_data_i,
    input  logic              icon_tx_success_i,
    output logic [ADDR_W-1:0] resp_addr_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic              resp_error_o
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]     mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [LOG2_DEPTH:0]   count;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     data_q;
    logic                  push, pop, capture;

`ifdef ICON_REQ_TIMEOUT_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] retry_q;
    logic               err_q;
    logic               timeout;
`endif

    // Occupancy never exceeds DEPTH, so the count MSB alone marks a full FIFO.
    assign req_ready_o = ~count[LOG2_DEPTH];
    assign push        = req_valid_i && req_ready_o;

    assign icon_tx_addr_o = addr_q;
    assign resp_addr_o    = addr_q;
    assign resp_data_o    = data_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake outputs; only one read is ever in flight.
    always_comb begin
        state_d             = state_q;
        pop                 = 1'b0;
        capture             = 1'b0;
        icon_tx_req_valid_o = 1'b0;
        resp_valid_o        = 1'b0;
`ifdef ICON_REQ_TIMEOUT_EN
        timeout             = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                icon_tx_req_valid_o = 1'b1;
                if (icon_tx_success_i) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end
`ifdef ICON_REQ_TIMEOUT_EN
                // Fires on the MAX_RETRY-th consecutive REQ cycle without success.
                else if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
                    timeout = 1'b1;
                    state_d = S_RESP;
                end
`endif
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= req_addr_i;
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Address latches on pop and stays put through REQ and RESP; data latches on success.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (pop)     addr_q <= mem[rd_ptr];
            if (capture) data_q <= icon_tx_data_i;
`ifdef ICON_REQ_TIMEOUT_EN
            if (timeout) data_q <= '0;
`endif
        end
    end

`ifdef ICON_REQ_TIMEOUT_EN
    // Retry counter runs only while waiting in REQ; error flag marks an aborted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            retry_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == S_REQ && state_d == S_REQ) retry_q <= retry_q + 1'b1;
            else                                      retry_q <= '0;
            if (capture)      err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;
        end
    end

    assign resp_error_o = err_q;
`else
    assign resp_error_o = 1'b0;
`endif

endmodule
